// File: rtl/tran_block_ctrl_pkg.sv
// Shared types for the AW-channel BLOCK sequencer: AW user encodings and FSM states.
package tran_block_ctrl_pkg;

    localparam int unsigned PAWUSER_WIDTH = 2;

    typedef enum logic [PAWUSER_WIDTH-1:0] {
        REGULAR = 2'd0,
        BLOCK   = 2'd1,
        DIVERT  = 2'd2,
        SPECIAL = 2'd3
    } pawuser_e;

    typedef enum logic [1:0] {
        BLK_IDLE,
        BLK_DRAIN,
        BLK_ISSUE,
        BLK_WAIT
    } blk_state_e;

    function automatic logic is_block_user(input logic [PAWUSER_WIDTH-1:0] user);
        return user == BLOCK;
    endfunction

endpackage

// File: rtl/tran_block_ctrl.sv
// AW sequencer in front of process_mem: passes regular AWs through and serialises BLOCK
// transactions (drain, issue alone, hold until block_fin); also acks spec_release.
module tran_block_ctrl
    import tran_block_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 256,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m_awvalid,
    input  logic [PAWUSER_WIDTH-1:0] m_awuser,
    output logic                     m_awready,
    output logic                     s_awvalid,
    input  logic                     s_awready,
    output logic                     to_block,
    input  logic                     pm_empty,
    input  logic                     pm_full,
    input  logic                     block_fin,
    input  logic                     spec_release,
    output logic                     release_ready,
    output logic                     blk_active,
    output logic [CNT_WIDTH-1:0]     blk_count,
    output logic                     err_timeout
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(DRAIN_TIMEOUT - 1);

    blk_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 empty_seen_q, empty_seen_d;
    logic                 err_q, err_d;
    logic                 rel_q, rel_d;
    logic                 spec_seen_q;
    logic                 is_blk;

    assign is_blk = m_awvalid & is_block_user(m_awuser);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLK_IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            empty_seen_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            empty_seen_q <= empty_seen_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        empty_seen_d = 1'b0;
        err_d        = err_q;
        s_awvalid    = 1'b0;
        m_awready    = 1'b0;
        to_block     = 1'b0;

        case (state_q)
            BLK_IDLE: begin
                s_awvalid = m_awvalid & ~pm_full & ~is_blk;
                m_awready = s_awready & s_awvalid;
                if (is_blk) begin
                    state_d = BLK_DRAIN;
                    timer_d = '0;
                end
            end
            BLK_DRAIN: begin
                to_block = 1'b1;
                // pm_empty lags by a register, so require it on two consecutive cycles
                empty_seen_d = pm_empty;
                if (timer_q != '1) begin
                    timer_d = timer_q + CNT_WIDTH'(1);
                end
                if (timer_q == TIMEOUT_LAST) begin
                    err_d = 1'b1;
                end
                if (pm_empty && empty_seen_q) begin
                    state_d = BLK_ISSUE;
                end
            end
            BLK_ISSUE: begin
                s_awvalid = m_awvalid;
                m_awready = s_awready;
                if (m_awvalid && s_awready) begin
                    state_d = BLK_WAIT;
                end
            end
            BLK_WAIT: begin
                to_block = 1'b1;
                if (block_fin) begin
                    state_d = BLK_IDLE;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = BLK_IDLE;
            end
        endcase
    end

    // Rising-edge acknowledge of spec_release, independent of the FSM
    assign rel_d = spec_release & ~spec_seen_q & ~rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_seen_q <= 1'b0;
            rel_q       <= 1'b0;
        end else begin
            spec_seen_q <= spec_release;
            rel_q       <= rel_d;
        end
    end

    assign release_ready = rel_q;
    assign blk_active    = (state_q != BLK_IDLE);
    assign blk_count     = cnt_q;
    assign err_timeout   = err_q;

    a_issue_user_block: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == BLK_ISSUE && m_awvalid) |-> is_block_user(m_awuser))
        else $error("non-BLOCK AW presented while issuing a BLOCK");

    a_block_fin_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        block_fin |-> (state_q == BLK_WAIT))
        else $warning("block_fin outside BLK_WAIT ignored");

endmodule

// File: tb/tb_tran_block_ctrl.sv
// Randomized self-checking bench for tran_block_ctrl against a sequence-level reference model.
module tb_tran_block_ctrl;
    import tran_block_ctrl_pkg::*;

    localparam int unsigned TB_TIMEOUT = 16;
    localparam int unsigned TB_CW      = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     m_awvalid;
    logic [PAWUSER_WIDTH-1:0] m_awuser;
    logic                     m_awready;
    logic                     s_awvalid;
    logic                     s_awready;
    logic                     to_block;
    logic                     pm_empty;
    logic                     pm_full;
    logic                     block_fin;
    logic                     spec_release;
    logic                     release_ready;
    logic                     blk_active;
    logic [TB_CW-1:0]         blk_count;
    logic                     err_timeout;

    always #5 clk = ~clk;

    tran_block_ctrl #(.DRAIN_TIMEOUT(TB_TIMEOUT), .CNT_WIDTH(TB_CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid(m_awvalid), .m_awuser(m_awuser), .m_awready(m_awready),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .to_block(to_block), .pm_empty(pm_empty), .pm_full(pm_full),
        .block_fin(block_fin), .spec_release(spec_release), .release_ready(release_ready),
        .blk_active(blk_active), .blk_count(blk_count), .err_timeout(err_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_ctrl(input string tag, input bit act, input bit tob, input bit sv, input bit mr);
        check_eq({tag, "_active"}, blk_active, act);
        check_eq({tag, "_to_block"}, to_block, tob);
        check_eq({tag, "_s_awvalid"}, s_awvalid, sv);
        check_eq({tag, "_m_awready"}, m_awready, mr);
    endtask

    task automatic idle_inputs();
        m_awvalid    = 1'b0;
        m_awuser     = REGULAR;
        s_awready    = 1'b0;
        pm_empty     = 1'b1;
        pm_full      = 1'b0;
        block_fin    = 1'b0;
        spec_release = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq({tag, "_count"}, blk_count, 0);
        check_eq({tag, "_err"}, err_timeout, 0);
        check_eq({tag, "_rel"}, release_ready, 0);
    endtask

    function automatic logic [PAWUSER_WIDTH-1:0] rand_regular_user();
        case ($urandom_range(0, 2))
            0:       return REGULAR;
            1:       return DIVERT;
            default: return SPECIAL;
        endcase
    endfunction

    // Random regular traffic in IDLE: forwarding rule is pure combinational arithmetic
    task automatic pass_rand(input int n);
        bit exp_sv;
        for (int i = 0; i < n; i++) begin
            m_awvalid = 1'($urandom_range(0, 1));
            m_awuser  = rand_regular_user();
            pm_full   = 1'($urandom_range(0, 1));
            s_awready = 1'($urandom_range(0, 1));
            pm_empty  = 1'($urandom_range(0, 1));
            sample();
            exp_sv = m_awvalid & ~pm_full;
            chk_ctrl("pass", 1'b0, 1'b0, exp_sv, exp_sv & s_awready);
            check_eq("pass_err", err_timeout, exp_err);
            next_cycle();
        end
    endtask

    // One BLOCK sequence: n_zero busy cycles, n_rand random pm_empty, then two empties
    task automatic block_seq(input int n_zero, input int n_rand, input bit finish, input int fin_wait);
        bit e[$];
        int d;
        int w;
        for (int i = 0; i < n_zero; i++) e.push_back(1'b0);
        for (int i = 0; i < n_rand; i++) e.push_back(1'($urandom_range(0, 1)));
        e.push_back(1'b1);
        e.push_back(1'b1);
        d = e.size();
        for (int j = 1; j < e.size(); j++) begin
            if (e[j-1] && e[j]) begin
                d = j + 1;
                break;
            end
        end

        m_awvalid = 1'b1;
        m_awuser  = BLOCK;
        pm_empty  = 1'b0;
        pm_full   = 1'($urandom_range(0, 1));
        s_awready = 1'($urandom_range(0, 1));
        sample();
        chk_ctrl("blk_arrive", 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();

        for (int j = 0; j < d; j++) begin
            pm_empty  = e[j];
            s_awready = 1'($urandom_range(0, 1));
            sample();
            chk_ctrl("drain", 1'b1, 1'b1, 1'b0, 1'b0);
            check_eq("drain_err", err_timeout, exp_err);
            if (j + 1 >= TB_TIMEOUT) exp_err = 1'b1;
            next_cycle();
        end

        pm_empty = 1'b1;
        w = $urandom_range(0, 3);
        for (int i = 0; i <= w; i++) begin
            s_awready = (i == w);
            sample();
            chk_ctrl("issue", 1'b1, 1'b0, 1'b1, s_awready);
            check_eq("issue_err", err_timeout, exp_err);
            next_cycle();
        end

        m_awuser  = REGULAR;
        s_awready = 1'b1;
        for (int i = 0; i < fin_wait; i++) begin
            m_awvalid = 1'($urandom_range(0, 1));
            sample();
            chk_ctrl("wait", 1'b1, 1'b1, 1'b0, 1'b0);
            check_eq("wait_count", blk_count, exp_cnt);
            next_cycle();
        end

        if (finish) begin
            block_fin = 1'b1;
            sample();
            chk_ctrl("wait_fin", 1'b1, 1'b1, 1'b0, 1'b0);
            next_cycle();
            block_fin = 1'b0;
            m_awvalid = 1'b0;
            exp_cnt   = (exp_cnt + 1) % (1 << TB_CW);
            sample();
            check_eq("fin_count", blk_count, exp_cnt);
            chk_ctrl("fin_idle", 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("fin_err", err_timeout, exp_err);
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        bit sp[$];
        bit prev1, prev2;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk_all_zero("reset_init");
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();

        // Reset mid BLK_WAIT clears everything at once
        block_seq(0, 4, 1'b1, 1);
        block_seq(1, 3, 1'b0, 2);
        m_awvalid = 1'b0;
        sample();
        check_eq("pre_reset_active", blk_active, 1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid");
        #2 rst_n = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
        next_cycle();

        // Five back-to-back regular AWs, zero added latency
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            m_awvalid = 1'b1;
            m_awuser  = rand_regular_user();
            s_awready = 1'b1;
            pm_full   = 1'b0;
            sample();
            if (m_awvalid && m_awready && s_awvalid) hs++;
            next_cycle();
        end
        check_eq("pass_handshakes", hs, 5);
        m_awvalid = 1'b1;
        pm_full   = 1'b1;
        sample();
        check_eq("pass_full_svalid", s_awvalid, 0);
        check_eq("pass_full_mready", m_awready, 0);
        next_cycle();
        pass_rand(30);

        // BLOCK with a 10-cycle busy drain, then random sequences
        block_seq(10, 0, 1'b1, 2);
        for (int k = 0; k < 6; k++) begin
            block_seq(0, $urandom_range(0, 8), 1'b1, $urandom_range(0, 3));
            pass_rand($urandom_range(1, 6));
        end

        // spec_release: directed rise/hold/drop/re-raise, then random levels
        sp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 20; i++) sp.push_back(1'($urandom_range(0, 1)));
        sp.push_back(1'b0);
        prev1 = 1'b0;
        prev2 = 1'b0;
        m_awvalid = 1'b0;
        for (int i = 0; i < sp.size(); i++) begin
            spec_release = sp[i];
            sample();
            check_eq("release_ready", release_ready, prev1 & ~prev2);
            prev2 = prev1;
            prev1 = sp[i];
            next_cycle();
        end
        spec_release = 1'b0;

        // Drain timeout: err sets after the 16th drain cycle and stays
        block_seq(20, 0, 1'b1, 1);
        check_eq("timeout_model", exp_err, 1);
        pass_rand(5);
        sample();
        check_eq("timeout_sticky", err_timeout, 1);
        next_cycle();

        // Counter wrap at 8'hFF
        while (exp_cnt != (1 << TB_CW) - 1) block_seq(0, 0, 1'b1, 0);
        sample();
        check_eq("count_ff", blk_count, 8'hFF);
        next_cycle();
        block_seq(0, 2, 1'b1, 1);
        sample();
        check_eq("count_wrap", blk_count, 0);
        next_cycle();

        // block_fin while IDLE is ignored
        block_fin = 1'b1;
        sample();
        check_eq("stray_fin_active", blk_active, 0);
        next_cycle();
        block_fin = 1'b0;
        sample();
        check_eq("stray_fin_active2", blk_active, 0);
        check_eq("stray_fin_count", blk_count, exp_cnt);
        next_cycle();

        // Reset clears the sticky error and the counter
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_final");
        #2 rst_n = 1'b1;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
